// File: rtl/mbist_scheduler.sv
// mbist_scheduler: walks enabled (memory, algorithm) pairs through the mbist
// engine, one pass at a time, and collects a fail map, a first-failure record
// and a timeout flag. A watchdog bounds the length of every pass.
module mbist_scheduler #(
    parameter int NUM_MEM    = 5,
    parameter int WDOG_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_MEM-1:0]    mem_enable,
    input  logic [2:0]            algo_enable,
    input  logic                  stop_on_fail,
    input  logic [WDOG_WIDTH-1:0] timeout_limit,
    output logic                  test_mode,
    output logic [2:0]            operation,
    output logic [2:0]            memory_sel,
    input  logic                  complete,
    input  logic                  error,
    input  logic                  force_terminate,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_MEM-1:0]    fail_map,
    output logic                  first_fail_valid,
    output logic [2:0]            first_fail_mem,
    output logic [1:0]            first_fail_algo,
    output logic                  timeout_flag,
    output logic                  aborted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]            state;
    logic [2:0]            cur_mem;
    logic [1:0]            cur_algo;
    logic                  cur_fail;
    logic                  res_valid;
    logic [WDOG_WIDTH-1:0] wdog;
    logic [WDOG_WIDTH-1:0] wdog_inc;
    logic                  wdog_hit;
    logic                  nxt_found;
    logic [2:0]            nxt_mem;
    logic [1:0]            nxt_algo;
    int                    cur_lin;

    // Saturating watchdog; wdog_inc is the number of RUN cycles including this one
    assign wdog_inc = (&wdog) ? wdog : wdog + WDOG_WIDTH'(1);
    assign wdog_hit = (timeout_limit != '0) && (wdog_inc == timeout_limit);

    // Find the next enabled pair after the current one (from the very start in IDLE)
    always_comb begin
        nxt_found = 1'b0;
        nxt_mem   = 3'd0;
        nxt_algo  = 2'd0;
        cur_lin   = (state == S_IDLE) ? -1 : (int'(cur_mem) * 3 + int'(cur_algo));
        for (int m = 0; m < NUM_MEM; m++) begin
            for (int a = 0; a < 3; a++) begin
                if (!nxt_found && mem_enable[m] && algo_enable[a] && (m * 3 + a > cur_lin)) begin
                    nxt_found = 1'b1;
                    nxt_mem   = 3'(m);
                    nxt_algo  = 2'(a);
                end
            end
        end
    end

    // Session sequencer and result collection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            cur_mem          <= 3'd0;
            cur_algo         <= 2'd0;
            cur_fail         <= 1'b0;
            res_valid        <= 1'b0;
            wdog             <= '0;
            fail_map         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_mem   <= 3'd0;
            first_fail_algo  <= 2'd0;
            timeout_flag     <= 1'b0;
            aborted          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        res_valid        <= 1'b0;
                        fail_map         <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_mem   <= 3'd0;
                        first_fail_algo  <= 2'd0;
                        timeout_flag     <= 1'b0;
                        aborted          <= 1'b0;
                        cur_fail         <= 1'b0;
                        if (nxt_found) begin
                            cur_mem  <= nxt_mem;
                            cur_algo <= nxt_algo;
                            state    <= S_SETUP;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    res_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                // DRAIN must keep waiting on complete even while abort is held
                S_DRAIN: begin
                    if (abort) aborted <= 1'b1;
                    if (!complete) state <= (aborted || abort) ? S_FINISH : S_NEXT;
                end
                default: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_DRAIN;
                    end else begin
                        case (state)
                            S_SETUP: begin
                                cur_fail <= 1'b0;
                                wdog     <= '0;
                                state    <= S_RUN;
                            end
                            S_RUN: begin
                                wdog <= wdog_inc;
                                if (error || force_terminate || wdog_hit) cur_fail <= 1'b1;
                                if (wdog_hit) timeout_flag <= 1'b1;
                                if (complete || force_terminate || wdog_hit) state <= S_RECORD;
                            end
                            S_RECORD: begin
                                if (cur_fail) begin
                                    fail_map <= fail_map | (NUM_MEM'(1) << cur_mem);
                                    if (!first_fail_valid) begin
                                        first_fail_valid <= 1'b1;
                                        first_fail_mem   <= cur_mem;
                                        first_fail_algo  <= cur_algo;
                                    end
                                end
                                state <= S_DRAIN;
                            end
                            S_NEXT: begin
                                if (!nxt_found || (stop_on_fail && cur_fail)) begin
                                    state <= S_FINISH;
                                end else begin
                                    cur_mem  <= nxt_mem;
                                    cur_algo <= nxt_algo;
                                    state    <= S_SETUP;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Outputs decoded from state; test_mode drops with the async reset
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FINISH);
    assign test_mode  = (state == S_RUN);
    assign memory_sel = cur_mem;
    assign operation  = (state == S_SETUP || state == S_RUN || state == S_RECORD)
                        ? (3'(cur_algo) + 3'd1) : 3'd0;
    assign pass       = (res_valid || state == S_FINISH) && !(|fail_map)
                        && !timeout_flag && !aborted;

endmodule
